// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared types and constants for the move validation driver
// Contents: FSM state encoding, reject codes, empty-square value, colour-bit helper.
package chess_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LATCH,
        ST_RD_SRC,
        ST_CHK_SRC,
        ST_START,
        ST_WAIT_VAL,
        ST_RD_DST,
        ST_CHK_DST,
        ST_WR_DST,
        ST_CLR_SRC,
        ST_DONE
    } state_t;

    typedef logic [1:0] reject_t;

    localparam reject_t REJ_NONE    = 2'd0;
    localparam reject_t REJ_EMPTY   = 2'd1;
    localparam reject_t REJ_ILLEGAL = 2'd2;
    localparam reject_t REJ_TIMEOUT = 2'd3;

    localparam int EMPTY_PIECE = 0;

    // The colour of a piece lives in the top bit of its board word.
    function automatic int colour_bit(input int piece_w);
        return piece_w - 1;
    endfunction

endpackage

// File: rtl/move_validation_driver_if.sv
// rtl/move_validation_driver_if.sv - request, validator and board-RAM signal bundle
// slave  : driver side (takes requests, drives validator start / read data, drives board RAM)
// master : environment side (game controller, validator and board RAM)
interface move_validation_driver_if #(
    parameter int PIECE_W = 4
);
    logic               move_request;
    logic [2:0]         req_piece_x;
    logic [2:0]         req_piece_y;
    logic [2:0]         req_move_x;
    logic [2:0]         req_move_y;
    logic               busy;
    logic               move_done;
    logic               move_accepted;
    logic [1:0]         reject_code;
    logic               start_validation;
    logic [2:0]         piece_x;
    logic [2:0]         piece_y;
    logic [2:0]         move_x;
    logic [2:0]         move_y;
    logic               validator_complete;
    logic               validator_valid;
    logic [2:0]         validate_x;
    logic [2:0]         validate_y;
    logic [PIECE_W-1:0] piece_read;
    logic [2:0]         mem_x;
    logic [2:0]         mem_y;
    logic               mem_wr_en;
    logic [PIECE_W-1:0] mem_wdata;
    logic [PIECE_W-1:0] mem_rdata;

    modport slave (
        input  move_request, req_piece_x, req_piece_y, req_move_x, req_move_y,
        input  validator_complete, validator_valid, validate_x, validate_y,
        input  mem_rdata,
        output busy, move_done, move_accepted, reject_code, start_validation,
        output piece_x, piece_y, move_x, move_y, piece_read,
        output mem_x, mem_y, mem_wr_en, mem_wdata
    );

    modport master (
        output move_request, req_piece_x, req_piece_y, req_move_x, req_move_y,
        output validator_complete, validator_valid, validate_x, validate_y,
        output mem_rdata,
        input  busy, move_done, move_accepted, reject_code, start_validation,
        input  piece_x, piece_y, move_x, move_y, piece_read,
        input  mem_x, mem_y, mem_wr_en, mem_wdata
    );

endinterface

// File: rtl/board_addr_mux.sv
// rtl/board_addr_mux.sv - board RAM address select from the driver state
// Ports: state (driver FSM state), src_*/dst_* (latched squares), val_* (validator
// read address), mem_x/mem_y (board RAM address; 0 when no access is needed).
module board_addr_mux
    import chess_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] src_x,
    input  logic [2:0] src_y,
    input  logic [2:0] dst_x,
    input  logic [2:0] dst_y,
    input  logic [2:0] val_x,
    input  logic [2:0] val_y,
    output logic [2:0] mem_x,
    output logic [2:0] mem_y
);

    always_comb begin
        mem_x = '0;
        mem_y = '0;
        case (state)
            ST_RD_SRC, ST_CHK_SRC, ST_CLR_SRC: begin
                mem_x = src_x;
                mem_y = src_y;
            end
            ST_RD_DST, ST_CHK_DST, ST_WR_DST: begin
                mem_x = dst_x;
                mem_y = dst_y;
            end
            ST_WAIT_VAL: begin
                mem_x = val_x;
                mem_y = val_y;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/move_validation_driver.sv
// rtl/move_validation_driver.sv - latches a move, runs the piece validator, commits to board RAM
// Ports: clk, reset (sync, active-high), bus (slave modport): move request in,
// busy/move_done/move_accepted/reject_code status out, validator start + read port,
// board RAM address/write port with 1-cycle synchronous read data.
module move_validation_driver
    import chess_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int PIECE_W        = 4
)
(
    input  logic                  clk,
    input  logic                  reset,
    move_validation_driver_if.slave bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int CBIT = colour_bit(PIECE_W);

    state_t             state;
    state_t             state_next;
    logic [2:0]         src_x, src_y, dst_x, dst_y;
    logic [PIECE_W-1:0] src_piece;
    logic [CNT_W-1:0]   to_cnt;
    reject_t            rej_q;
    logic               acc_q;
    logic               rej_load;
    reject_t            rej_val;
    logic [2:0]         addr_x, addr_y;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        rej_load   = 1'b0;
        rej_val    = REJ_NONE;
        case (state)
            ST_IDLE:    if (bus.move_request) state_next = ST_LATCH;
            ST_LATCH:   state_next = ST_RD_SRC;
            ST_RD_SRC:  state_next = ST_CHK_SRC;
            ST_CHK_SRC: begin
                if (bus.mem_rdata == PIECE_W'(EMPTY_PIECE)) begin
                    state_next = ST_DONE;
                    rej_load   = 1'b1;
                    rej_val    = REJ_EMPTY;
                end else begin
                    state_next = ST_START;
                end
            end
            ST_START:   state_next = ST_WAIT_VAL;
            ST_WAIT_VAL: begin
                // A verdict arriving on the last allowed cycle still wins over the timeout.
                if (bus.validator_complete) begin
                    if (bus.validator_valid) begin
                        state_next = ST_RD_DST;
                    end else begin
                        state_next = ST_DONE;
                        rej_load   = 1'b1;
                        rej_val    = REJ_ILLEGAL;
                    end
                end else if (to_cnt == CNT_LAST) begin
                    state_next = ST_DONE;
                    rej_load   = 1'b1;
                    rej_val    = REJ_TIMEOUT;
                end
            end
            ST_RD_DST:  state_next = ST_CHK_DST;
            ST_CHK_DST: begin
                // Own-colour capture also catches a source==destination move the validator let through.
                if ((bus.mem_rdata != PIECE_W'(EMPTY_PIECE)) &&
                    (bus.mem_rdata[CBIT] == src_piece[CBIT])) begin
                    state_next = ST_DONE;
                    rej_load   = 1'b1;
                    rej_val    = REJ_ILLEGAL;
                end else begin
                    state_next = ST_WR_DST;
                end
            end
            ST_WR_DST:  state_next = ST_CLR_SRC;
            ST_CLR_SRC: state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_x     <= '0;
            src_y     <= '0;
            dst_x     <= '0;
            dst_y     <= '0;
            src_piece <= '0;
            to_cnt    <= '0;
            rej_q     <= REJ_NONE;
            acc_q     <= 1'b0;
        end else begin
            if (state == ST_LATCH) begin
                src_x <= bus.req_piece_x;
                src_y <= bus.req_piece_y;
                dst_x <= bus.req_move_x;
                dst_y <= bus.req_move_y;
                rej_q <= REJ_NONE;
                acc_q <= 1'b0;
            end
            if (state == ST_CHK_SRC) src_piece <= bus.mem_rdata;
            if (state == ST_START) begin
                to_cnt <= '0;
            end else if ((state == ST_WAIT_VAL) && (to_cnt != '1)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (rej_load) rej_q <= rej_val;
            // Both board writes are issued by the time DONE is reached.
            if (state == ST_CLR_SRC) acc_q <= 1'b1;
        end
    end

    board_addr_mux u_addr_mux (
        .state (state),
        .src_x (src_x),
        .src_y (src_y),
        .dst_x (dst_x),
        .dst_y (dst_y),
        .val_x (bus.validate_x),
        .val_y (bus.validate_y),
        .mem_x (addr_x),
        .mem_y (addr_y)
    );

    always_comb begin
        bus.busy             = (state != ST_IDLE);
        bus.move_done        = (state == ST_DONE);
        bus.start_validation = (state == ST_START);
        bus.mem_wr_en        = (state == ST_WR_DST) || (state == ST_CLR_SRC);
        bus.mem_wdata        = (state == ST_WR_DST) ? src_piece : '0;
        bus.piece_read       = (state == ST_WAIT_VAL) ? bus.mem_rdata : '0;
        bus.mem_x            = addr_x;
        bus.mem_y            = addr_y;
        bus.piece_x          = src_x;
        bus.piece_y          = src_y;
        bus.move_x           = dst_x;
        bus.move_y           = dst_y;
        bus.move_accepted    = acc_q;
        bus.reject_code      = rej_q;
    end

endmodule

// File: tb/tb_move_validation_driver.sv
// tb/tb_move_validation_driver.sv - directed bench with board RAM model and result scoreboard
module tb_move_validation_driver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    move_validation_driver_if #(.PIECE_W(4)) bus();

    move_validation_driver #(.TIMEOUT_CYCLES(64), .PIECE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0] board [64];
    logic       poke_en;
    logic [5:0] poke_addr;
    logic [3:0] poke_data;

    always @(posedge clk) begin
        if (poke_en)            board[poke_addr] <= poke_data;
        else if (bus.mem_wr_en) board[{bus.mem_x, bus.mem_y}] <= bus.mem_wdata;
        bus.mem_rdata <= board[{bus.mem_x, bus.mem_y}];
    end

    typedef struct {
        logic       acc;
        logic [1:0] code;
    } exp_t;
    exp_t sb[$];

    int start_cnt = 0;
    int wr_cnt    = 0;
    int done_cnt  = 0;
    int wait_cnt  = 0;
    int last_wait = 0;
    bit in_wait   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            in_wait = 0;
        end else begin
            if (bus.mem_wr_en) wr_cnt++;
            if (bus.start_validation) begin
                start_cnt++;
                in_wait  = 1;
                wait_cnt = 0;
            end else if (bus.move_done) begin
                done_cnt++;
                last_wait = wait_cnt;
                in_wait   = 0;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL unexpected_done observed=move_done expected=none");
                end else begin
                    e = sb.pop_front();
                    check("move_accepted", 32'(bus.move_accepted), 32'(e.acc));
                    check("reject_code", 32'(bus.reject_code), 32'(e.code));
                end
            end else if (in_wait) begin
                wait_cnt++;
            end
        end
    end

    task automatic poke(input logic [2:0] x, input logic [2:0] y, input logic [3:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = {x, y};
        poke_data = d;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    task automatic pulse_req(input logic [2:0] px, input logic [2:0] py,
                             input logic [2:0] mx, input logic [2:0] my);
        @(negedge clk);
        bus.req_piece_x  = px;
        bus.req_piece_y  = py;
        bus.req_move_x   = mx;
        bus.req_move_y   = my;
        bus.move_request = 1'b1;
        @(negedge clk);
        bus.move_request = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int i;
        i = 0;
        while (done_cnt == d0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        @(negedge clk);
        #1;
        check("done_seen", 32'(done_cnt), 32'(d0 + 1));
    endtask

    task automatic do_move(input logic [2:0] px, input logic [2:0] py,
                           input logic [2:0] mx, input logic [2:0] my,
                           input logic acc, input logic [1:0] code);
        int d0;
        exp_t e;
        d0     = done_cnt;
        e.acc  = acc;
        e.code = code;
        sb.push_back(e);
        pulse_req(px, py, mx, my);
        wait_done(d0, 200);
    endtask

    initial begin
        int s0, w0, d0, k;
        exp_t e;
        reset                  = 1'b1;
        poke_en                = 1'b0;
        poke_addr              = '0;
        poke_data              = '0;
        bus.move_request       = 1'b0;
        bus.req_piece_x        = '0;
        bus.req_piece_y        = '0;
        bus.req_move_x         = '0;
        bus.req_move_y         = '0;
        bus.validator_complete = 1'b0;
        bus.validator_valid    = 1'b0;
        bus.validate_x         = '0;
        bus.validate_y         = '0;
        for (int i = 0; i < 64; i++) poke(3'(i >> 3), 3'(i), 4'h0);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_move_done", 32'(bus.move_done), 0);
        check("rst_accepted", 32'(bus.move_accepted), 0);
        check("rst_reject", 32'(bus.reject_code), 0);
        check("rst_start", 32'(bus.start_validation), 0);
        check("rst_wr_en", 32'(bus.mem_wr_en), 0);
        check("rst_wdata", 32'(bus.mem_wdata), 0);
        check("rst_coords", 32'({bus.piece_x, bus.piece_y, bus.move_x, bus.move_y}), 0);
        reset = 1'b0;

        // Bishop (2,0) -> (4,2), empty destination, validator approves at once.
        poke(3'd2, 3'd0, 4'b0011);
        bus.validator_complete = 1'b1;
        bus.validator_valid    = 1'b1;
        s0 = start_cnt;
        w0 = wr_cnt;
        do_move(3'd2, 3'd0, 3'd4, 3'd2, 1'b1, 2'd0);
        check("bishop_start_cnt", 32'(start_cnt - s0), 1);
        check("bishop_wr_cnt", 32'(wr_cnt - w0), 2);
        check("bishop_dst", 32'(board[{3'd4, 3'd2}]), 32'h3);
        check("bishop_src", 32'(board[{3'd2, 3'd0}]), 0);
        check("bishop_latched", 32'({bus.piece_x, bus.piece_y, bus.move_x, bus.move_y}),
              32'({3'd2, 3'd0, 3'd4, 3'd2}));

        // Empty source square.
        s0 = start_cnt;
        w0 = wr_cnt;
        do_move(3'd5, 3'd5, 3'd4, 3'd2, 1'b0, 2'd1);
        check("empty_start_cnt", 32'(start_cnt - s0), 0);
        check("empty_wr_cnt", 32'(wr_cnt - w0), 0);

        // Validator rejects.
        poke(3'd2, 3'd0, 4'b0011);
        poke(3'd4, 3'd2, 4'b0000);
        bus.validator_valid = 1'b0;
        w0 = wr_cnt;
        do_move(3'd2, 3'd0, 3'd4, 3'd2, 1'b0, 2'd2);
        check("illegal_wr_cnt", 32'(wr_cnt - w0), 0);

        // Own-colour capture rejected, board unchanged.
        bus.validator_valid = 1'b1;
        poke(3'd4, 3'd2, 4'b0101);
        w0 = wr_cnt;
        do_move(3'd2, 3'd0, 3'd4, 3'd2, 1'b0, 2'd2);
        check("own_wr_cnt", 32'(wr_cnt - w0), 0);
        check("own_dst", 32'(board[{3'd4, 3'd2}]), 32'h5);
        check("own_src", 32'(board[{3'd2, 3'd0}]), 32'h3);

        // Opponent capture accepted.
        poke(3'd4, 3'd2, 4'b1101);
        do_move(3'd2, 3'd0, 3'd4, 3'd2, 1'b1, 2'd0);
        check("cap_dst", 32'(board[{3'd4, 3'd2}]), 32'h3);
        check("cap_src", 32'(board[{3'd2, 3'd0}]), 0);

        // Timeout with a second request ignored while busy.
        poke(3'd1, 3'd1, 4'b1010);
        bus.validator_complete = 1'b0;
        d0 = done_cnt;
        w0 = wr_cnt;
        e.acc  = 1'b0;
        e.code = 2'd3;
        sb.push_back(e);
        pulse_req(3'd1, 3'd1, 3'd3, 3'd3);
        for (k = 0; k < 10; k++) @(negedge clk);
        pulse_req(3'd4, 3'd2, 3'd0, 3'd0);
        wait_done(d0, 200);
        check("timeout_wait_cycles", 32'(last_wait), 64);
        check("timeout_wr_cnt", 32'(wr_cnt - w0), 0);
        for (k = 0; k < 20; k++) @(negedge clk);
        check("ignored_req_done_cnt", 32'(done_cnt), 32'(d0 + 1));
        check("ignored_req_busy", 32'(bus.busy), 0);

        // Reset while waiting on the validator.
        s0 = start_cnt;
        w0 = wr_cnt;
        pulse_req(3'd1, 3'd1, 3'd3, 3'd3);
        k = 0;
        while (start_cnt == s0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        check("rstwait_started", 32'(start_cnt - s0), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstwait_busy", 32'(bus.busy), 0);
        check("rstwait_outputs", 32'({bus.move_done, bus.move_accepted, bus.reject_code,
                                      bus.start_validation, bus.mem_wr_en, bus.mem_wdata}), 0);
        check("rstwait_coords", 32'({bus.piece_x, bus.piece_y, bus.move_x, bus.move_y}), 0);
        reset = 1'b0;
        for (k = 0; k < 10; k++) @(negedge clk);
        check("rstwait_wr_cnt", 32'(wr_cnt - w0), 0);
        check("rstwait_src", 32'(board[{3'd1, 3'd1}]), 32'ha);
        check("sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/move_validation_driver.md
Name: move_validation_driver

Overview:
Initiator for the per-piece validators and responder on their board-memory read port. Accepts a move request from the cursor/input logic and latches it. Reads the source square, starts the validator and serves its board reads. On a valid result, commits the move to board memory (write destination, clear source). Sits between the game controller and the board RAM.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles in WAIT_VAL before the move is rejected with a timeout
PIECE_W, 4, board-memory word width; 0 = empty square, bit [PIECE_W-1] = colour

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
move_request  input  1  one-cycle request pulse; sampled only in IDLE
req_piece_x, req_piece_y  input  3 each  source square
req_move_x, req_move_y  input  3 each  destination square
busy  output  1  high in every state except IDLE
move_done  output  1  one-cycle pulse when a request finishes
move_accepted  output  1  valid with move_done: move committed
reject_code  output  2  valid with move_done: 0 = none, 1 = empty source, 2 = illegal/own-capture, 3 = timeout
start_validation  output  1  one-cycle start pulse to validator
piece_x, piece_y, move_x, move_y  output  3 each  latched request; held stable from LATCH until IDLE
validator_complete  input  1  validator finished; may be combinational and may stay high
validator_valid  input  1  validator verdict; qualified by validator_complete
validate_x, validate_y  input  3 each  validator read address
piece_read  output  PIECE_W  read data returned to validator
mem_x, mem_y  output  3 each  board RAM address
mem_wr_en  output  1  board RAM write enable
mem_wdata  output  PIECE_W  board RAM write data
mem_rdata  input  PIECE_W  board RAM read data; 1-cycle synchronous read latency

Behaviour:
- Reset: state IDLE. All outputs 0: busy, move_done, move_accepted, reject_code, start_validation, mem_wr_en, mem_wdata, latched coordinates, timeout counter.
- FSM states: IDLE, LATCH, RD_SRC, CHK_SRC, START, WAIT_VAL, RD_DST, CHK_DST, WR_DST, CLR_SRC, DONE.
- IDLE: when move_request=1, go to LATCH. Requests in any other state are ignored, not queued.
- LATCH: register the req_* fields into piece_*/move_*. Go to RD_SRC.
- RD_SRC: mem address = source square. CHK_SRC: register mem_rdata as src_piece. If it is 0, go to DONE with reject_code=1. Otherwise go to START.
- START: start_validation=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_VAL.
- WAIT_VAL: mem_x/mem_y = validate_x/validate_y and piece_read = mem_rdata; one-cycle read latency is visible to the validator. Evaluate validator_complete from the first WAIT_VAL cycle onward.
  - complete=1 and valid=1: go to RD_DST.
  - complete=1 and valid=0: go to DONE, reject_code=2.
  - Counter reaches TIMEOUT_CYCLES-1 with complete=0: go to DONE, reject_code=3.
  - complete takes priority over timeout in the same cycle.
- piece_read outside WAIT_VAL: 0.
- RD_DST / CHK_DST: read the destination. If it is non-zero and its colour bit equals src_piece's colour bit, go to DONE with reject_code=2. Otherwise go to WR_DST.
- WR_DST: mem_wr_en=1, address = destination, mem_wdata = src_piece.
- CLR_SRC: mem_wr_en=1, address = source, mem_wdata = 0.
- mem_wr_en is high only in WR_DST and CLR_SRC.
- DONE: move_done=1 for one cycle; move_accepted=1 iff reject_code=0. Next state IDLE.
- move_accepted and reject_code hold their values until the next LATCH.
- Source == destination: the validator is relied on to reject. If it does not, CHK_DST sees own colour and rejects with code 2.
- Reset mid-operation: return to IDLE next edge. No further writes. A board write already issued is not undone.
- Timeout counter: clog2(TIMEOUT_CYCLES) bits, saturating; no wrap.

Decomposition:
- Shared package chess_pkg:
  - FSM state encoding
  - reject code constants (REJ_NONE, REJ_EMPTY, REJ_ILLEGAL, REJ_TIMEOUT)
  - EMPTY_PIECE = 0
  - colour-bit index
- One sub-module, board_addr_mux: selects mem_x/mem_y between the source, destination and validator addresses from the state.

Test Plan:
- Bishop piece 4'b0011 at (2,0); request to (4,2); dest empty; validator complete=1, valid=1 -> start pulse 1 cycle; (4,2)=3, (2,0)=0; move_done with accepted=1, code 0.
- Source (5,5) empty -> no start_validation, no write; move_done, code 1.
- Validator returns complete=1, valid=0 -> no mem_wr_en at any cycle; code 2.
- Dest (4,2) holds 4'b0101 (same colour as 4'b0011) -> code 2, board unchanged. Dest 4'b1101 -> accepted; (4,2)=3.
- validator_complete held 0 -> exactly TIMEOUT_CYCLES cycles in WAIT_VAL, then code 3. Second move_request during busy -> ignored.
- Reset asserted in WAIT_VAL -> next cycle IDLE, all outputs 0, no write issued.
